// File: rtl/ahb_pkg.sv
// Shared types and encodings for the AHB-lite N-slave decoder.
//   ds_state_e     : default-slave error FSM states
//   HRESP_*        : response encodings
//   DSEL_*         : data-phase owner encoding (0..15 = slave index, DEF, NONE)
package ahb_pkg;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Owner codes: values below DSEL_DEF are slave indices (NUM_SLV <= 16).
  localparam int unsigned       DSEL_W    = 5;
  localparam logic [DSEL_W-1:0] DSEL_DEF  = 5'd16;
  localparam logic [DSEL_W-1:0] DSEL_NONE = 5'd17;

endpackage

// File: rtl/ahb_default_slave.sv
// Internal default slave: answers unmapped (or aborted) transfers with a
// two-cycle AHB ERROR response.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   start     : enter the error sequence from idle
//   restart   : re-enter the error sequence from the second error cycle
//   hready    : registered hreadyout of the default slave
//   hresp     : registered response of the default slave
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic clk,
  input  logic rstn,
  input  logic start,
  input  logic restart,
  output logic hready,
  output logic hresp
);

  ds_state_e state;

  // Error FSM with registered outputs: ERR1 stalls with ERROR, ERR2 completes it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= DS_IDLE;
      hready <= 1'b1;
      hresp  <= HRESP_OKAY;
    end else begin
      case (state)
        DS_IDLE: begin
          if (start) begin
            state  <= DS_ERR1;
            hready <= 1'b0;
            hresp  <= HRESP_ERROR;
          end
        end
        DS_ERR1: begin
          state  <= DS_ERR2;
          hready <= 1'b1;
          hresp  <= HRESP_ERROR;
        end
        DS_ERR2: begin
          if (restart) begin
            state  <= DS_ERR1;
            hready <= 1'b0;
            hresp  <= HRESP_ERROR;
          end else begin
            state  <= DS_IDLE;
            hready <= 1'b1;
            hresp  <= HRESP_OKAY;
          end
        end
        default: begin
          state  <= DS_IDLE;
          hready <= 1'b1;
          hresp  <= HRESP_OKAY;
        end
      endcase
    end
  end

endmodule

// File: rtl/ahb_lite_decoder_n.sv
// Single-master AHB-lite fabric for NUM_SLV slaves: base/mask address decode
// with lowest-index priority, one-hot selects, registered data-phase owner,
// read-data/response mux and an internal ERROR default slave.
// Optional macro AHB_DEC_TIMEOUT_EN: aborts a slave that stalls for
// TIMEOUT_CYC cycles, blocks it until reset and pulses to_evt.
// Ports:
//   clk, rstn                       : clock, asynchronous active-low reset
//   m_haddr/m_haddr_ctrl/m_hwrite   : master address phase
//   m_hwdata                        : master write data
//   m_hready/m_hresp/m_hrdata       : data-phase response to master
//   s_haddr/s_haddr_ctrl/s_hwrite/
//   s_hwdata/s_hready_in            : broadcast to slaves
//   s_hsel                          : one-hot slave select
//   s_hready/s_hresp/s_hrdata       : per-slave responses (packed)
//   to_evt                          : one-cycle pulse on a timeout abort
module ahb_lite_decoder_n
  import ahb_pkg::*;
#(
  parameter int unsigned               NUM_SLV     = 4,
  parameter int unsigned               ADDR_W      = 32,
  parameter int unsigned               DATA_W      = 32,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE    = '0,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK    = '0,
  parameter int unsigned               TIMEOUT_CYC = 256
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [ADDR_W-1:0]         m_haddr,
  input  logic                      m_haddr_ctrl,
  input  logic                      m_hwrite,
  input  logic [DATA_W-1:0]         m_hwdata,
  output logic                      m_hready,
  output logic                      m_hresp,
  output logic [DATA_W-1:0]         m_hrdata,
  output logic [ADDR_W-1:0]         s_haddr,
  output logic                      s_haddr_ctrl,
  output logic                      s_hwrite,
  output logic [DATA_W-1:0]         s_hwdata,
  output logic                      s_hready_in,
  output logic [NUM_SLV-1:0]        s_hsel,
  input  logic [NUM_SLV-1:0]        s_hready,
  input  logic [NUM_SLV-1:0]        s_hresp,
  input  logic [NUM_SLV*DATA_W-1:0] s_hrdata,
  output logic                      to_evt
);

  logic [NUM_SLV-1:0] blocked;
  logic [NUM_SLV-1:0] hit_vec;
  logic [NUM_SLV-1:0] win_vec;
  logic               hit;
  logic [DSEL_W-1:0]  hit_idx;
  logic [DSEL_W-1:0]  dsel;
  logic               def_accept;
  logic               abort;
  logic               ds_hready;
  logic               ds_hresp;

  // Per-slave address match, excluding slaves blocked by a timeout abort.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      hit_vec[i] = ((m_haddr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])
                   && !blocked[i];
    end
  end

  // Priority pick: scanning downward leaves the lowest matching index last.
  always_comb begin
    win_vec = '0;
    hit_idx = DSEL_NONE;
    hit     = 1'b0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        win_vec    = '0;
        win_vec[i] = 1'b1;
        hit_idx    = DSEL_W'(i);
        hit        = 1'b1;
      end
    end
  end

  assign s_hsel       = m_haddr_ctrl ? win_vec : '0;
  assign s_haddr      = m_haddr;
  assign s_haddr_ctrl = m_haddr_ctrl;
  assign s_hwrite     = m_hwrite;
  assign s_hwdata     = m_hwdata;
  assign s_hready_in  = m_hready;

  assign def_accept = m_hready && m_haddr_ctrl && !hit;

  // Data-phase owner: captured when the bus is ready, redirected to DEF on abort.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dsel <= DSEL_NONE;
    end else if (m_hready) begin
      if (!m_haddr_ctrl) dsel <= DSEL_NONE;
      else if (hit)      dsel <= hit_idx;
      else               dsel <= DSEL_DEF;
    end else if (abort) begin
      dsel <= DSEL_DEF;
    end
  end

  // Response mux; NONE falls through to the idle defaults.
  always_comb begin
    m_hready = 1'b1;
    m_hresp  = HRESP_OKAY;
    m_hrdata = '0;
    if (dsel == DSEL_DEF) begin
      m_hready = ds_hready;
      m_hresp  = ds_hresp;
    end else begin
      for (int i = 0; i < NUM_SLV; i++) begin
        if (dsel == DSEL_W'(i)) begin
          m_hready = s_hready[i];
          m_hresp  = s_hresp[i];
          m_hrdata = s_hrdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  ahb_default_slave u_def (
    .clk     (clk),
    .rstn    (rstn),
    .start   (def_accept || abort),
    .restart (def_accept),
    .hready  (ds_hready),
    .hresp   (ds_hresp)
  );

`ifdef AHB_DEC_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;

  logic [CNT_W-1:0] to_cnt;
  logic             stall;

  // A real slave owns the data phase and holds the bus (m_hready mirrors it).
  assign stall = (dsel != DSEL_DEF) && (dsel != DSEL_NONE) && !m_hready;
  assign abort = stall && (to_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Any owner change implies m_hready was high, so !stall also covers it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt <= '0;
    end else if (!stall || abort) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end

  // Sticky block of the aborted slave plus event pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blocked <= '0;
      to_evt  <= 1'b0;
    end else begin
      to_evt <= abort;
      for (int i = 0; i < NUM_SLV; i++) begin
        if (abort && (dsel == DSEL_W'(i))) blocked[i] <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  assign abort          = 1'b0;
  assign blocked        = '0;
  assign to_evt         = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

endmodule

// File: tb/tb_ahb_lite_decoder_n.sv
// Scoreboard bench for ahb_lite_decoder_n with two behavioural slaves.
// Driver pushes expected responses; a negedge monitor pops and compares.
module tb_ahb_lite_decoder_n;

  localparam int unsigned NS = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam logic [NS*AW-1:0] BASE = {32'h2000_0000, 32'h1000_0000};
  localparam logic [NS*AW-1:0] MASK = {32'hF000_0000, 32'hF000_0000};
  localparam logic [31:0] RD0 = 32'h1234_5678;
  localparam logic [31:0] RD1 = 32'hDEAD_BEEF;
`ifdef AHB_DEC_TIMEOUT_EN
  localparam int EXP_EVT = 1;
`else
  localparam int EXP_EVT = 0;
`endif

  logic              clk;
  logic              rstn;
  logic [AW-1:0]     m_haddr;
  logic              m_haddr_ctrl;
  logic              m_hwrite;
  logic [DW-1:0]     m_hwdata;
  logic              m_hready;
  logic              m_hresp;
  logic [DW-1:0]     m_hrdata;
  logic [AW-1:0]     s_haddr;
  logic              s_haddr_ctrl;
  logic              s_hwrite;
  logic [DW-1:0]     s_hwdata;
  logic              s_hready_in;
  logic [NS-1:0]     s_hsel;
  logic [NS-1:0]     s_hready;
  logic [NS-1:0]     s_hresp;
  logic [NS*DW-1:0]  s_hrdata;
  logic              to_evt;

  ahb_lite_decoder_n #(
    .NUM_SLV(NS), .ADDR_W(AW), .DATA_W(DW),
    .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .rstn(rstn),
    .m_haddr(m_haddr), .m_haddr_ctrl(m_haddr_ctrl), .m_hwrite(m_hwrite), .m_hwdata(m_hwdata),
    .m_hready(m_hready), .m_hresp(m_hresp), .m_hrdata(m_hrdata),
    .s_haddr(s_haddr), .s_haddr_ctrl(s_haddr_ctrl), .s_hwrite(s_hwrite), .s_hwdata(s_hwdata),
    .s_hready_in(s_hready_in), .s_hsel(s_hsel),
    .s_hready(s_hready), .s_hresp(s_hresp), .s_hrdata(s_hrdata),
    .to_evt(to_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        resp;
    logic        chk_rdata;
    logic [31:0] rdata;
    int          waits;
    logic        chk_wresp;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] hsel_q[$];

  // Behavioural slaves: programmable wait states, fixed read data.
  logic [NS-1:0] act;
  logic [NS-1:0] wr;
  int            wcnt[NS];
  int            cfg_waits[NS];
  logic [31:0]   last_wdata[NS];

  always_comb begin
    for (int i = 0; i < NS; i++) s_hready[i] = !act[i] || (wcnt[i] == 0);
  end
  assign s_hresp  = '0;
  assign s_hrdata = {RD1, RD0};

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      act <= '0;
      wr  <= '0;
      for (int i = 0; i < NS; i++) wcnt[i] <= 0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (act[i] && wcnt[i] == 0 && wr[i]) last_wdata[i] <= s_hwdata;
        if (s_hready_in && s_hsel[i]) begin
          act[i]  <= 1'b1;
          wr[i]   <= s_hwrite;
          wcnt[i] <= cfg_waits[i];
        end else if (act[i] && wcnt[i] == 0) begin
          act[i] <= 1'b0;
        end else if (act[i]) begin
          wcnt[i] <= wcnt[i] - 1;
        end
      end
    end
  end

  // Monitor / scoreboard
  int   vectors = 0;
  int   miscompares = 0;
  int   wcount = 0;
  int   evt_cnt = 0;
  logic in_dp = 1'b0;
  logic final_req = 1'b0;
  logic final_done = 1'b0;
  exp_t e;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      in_dp  = 1'b0;
      wcount = 0;
      chk("rst_hready", 32'(m_hready), 32'd1);
      chk("rst_hresp", 32'(m_hresp), 32'd0);
      chk("rst_hrdata", m_hrdata, 32'd0);
      chk("rst_hsel", 32'(s_hsel), 32'd0);
    end else begin
      if (to_evt) evt_cnt++;
      if (!in_dp && !m_haddr_ctrl) begin
        chk("idle_hready", 32'(m_hready), 32'd1);
        chk("idle_hresp", 32'(m_hresp), 32'd0);
        chk("idle_hrdata", m_hrdata, 32'd0);
        chk("idle_hsel", 32'(s_hsel), 32'd0);
      end
      if (in_dp) begin
        if (!m_hready) begin
          wcount++;
          if (sb.size() > 0 && sb[0].chk_wresp) chk("wait_hresp", 32'(m_hresp), 32'(sb[0].resp));
        end else if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          wcount = 0;
          $display("FAIL sb_empty: transfer completed with 0 expected entries, required 1");
        end else begin
          e = sb.pop_front();
          chk("done_hresp", 32'(m_hresp), 32'(e.resp));
          if (e.chk_rdata) chk("done_hrdata", m_hrdata, e.rdata);
          chk("done_waits", 32'(wcount), 32'(e.waits));
          wcount = 0;
        end
      end
      if (m_hready && m_haddr_ctrl && hsel_q.size() > 0) chk("addr_hsel", 32'(s_hsel), 32'(hsel_q.pop_front()));
      if (m_hready) in_dp = m_haddr_ctrl;
      if (final_req && !final_done) begin
        chk("wdata_slv0", last_wdata[0], 32'hA5A5_0001);
        chk("wdata_slv1", last_wdata[1], 32'hC3C3_0002);
        chk("to_evt_count", 32'(evt_cnt), 32'(EXP_EVT));
        final_done = 1'b1;
      end
    end
  end

  // Driver
  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (!m_hready) begin
      n++;
      if (n > 300) begin
        $display("FAIL accept_timeout: m_hready 0 for %0d cycles, required 1", n);
        $fatal(1, "bench aborted");
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] addr, input logic wrt, input logic [31:0] wdata,
                       input logic [1:0] hsel, input logic resp, input logic chk_rd,
                       input logic [31:0] rdata, input int waits, input logic chk_wresp);
    exp_t x;
    x.resp = resp; x.chk_rdata = chk_rd; x.rdata = rdata; x.waits = waits; x.chk_wresp = chk_wresp;
    m_haddr      = addr;
    m_hwrite     = wrt;
    m_haddr_ctrl = 1'b1;
    sb.push_back(x);
    hsel_q.push_back(hsel);
    wait_accept();
    m_haddr_ctrl = 1'b0;
    m_hwdata     = wdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rstn = 1'b0; m_haddr = '0; m_haddr_ctrl = 1'b0; m_hwrite = 1'b0; m_hwdata = '0;
    cfg_waits[0] = 0; cfg_waits[1] = 0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    idle(2);

    // Read slave 1 with two wait states
    cfg_waits[1] = 2;
    issue(32'h2000_0004, 1'b0, 32'h0, 2'b10, 1'b0, 1'b1, RD1, 2, 1'b1);
    idle(3);

    // Back-to-back write slave 0, read slave 1
    cfg_waits[0] = 0; cfg_waits[1] = 0;
    issue(32'h1000_0000, 1'b1, 32'hA5A5_0001, 2'b01, 1'b0, 1'b0, 32'h0, 0, 1'b1);
    issue(32'h2000_0000, 1'b0, 32'h0, 2'b10, 1'b0, 1'b1, RD1, 0, 1'b1);
    idle(3);

    // Unmapped: two-cycle ERROR
    issue(32'h5000_0000, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 32'h0, 1, 1'b1);
    idle(3);

    // Two unmapped back-to-back
    issue(32'h5000_0000, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 32'h0, 1, 1'b1);
    issue(32'h6000_0010, 1'b1, 32'h0, 2'b00, 1'b1, 1'b1, 32'h0, 1, 1'b1);
    idle(3);

    // Unmapped followed by a mapped read with one wait state
    cfg_waits[0] = 1;
    issue(32'h7000_0000, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 32'h0, 1, 1'b1);
    issue(32'h1000_0004, 1'b0, 32'h0, 2'b01, 1'b0, 1'b1, RD0, 1, 1'b1);
    idle(3);

    // Slow write to slave 1 then fast read from slave 0
    cfg_waits[0] = 0; cfg_waits[1] = 3;
    issue(32'h2000_0010, 1'b1, 32'hC3C3_0002, 2'b10, 1'b0, 1'b0, 32'h0, 3, 1'b1);
    issue(32'h1000_0008, 1'b0, 32'h0, 2'b01, 1'b0, 1'b1, RD0, 0, 1'b1);
    idle(3);

`ifdef AHB_DEC_TIMEOUT_EN
    // Stalled slave 0: 8 stall cycles then ERROR; afterwards slave 0 is blocked
    cfg_waits[0] = 1000;
    issue(32'h1000_0000, 1'b0, 32'h0, 2'b01, 1'b1, 1'b1, 32'h0, 9, 1'b0);
    cfg_waits[0] = 0;
    issue(32'h1000_0000, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 32'h0, 1, 1'b1);
    idle(3);
`endif

    // Reset in the middle of a wait-stated data phase
    cfg_waits[1] = 5;
    m_haddr = 32'h2000_0008; m_hwrite = 1'b0; m_haddr_ctrl = 1'b1;
    hsel_q.push_back(2'b10);
    wait_accept();
    m_haddr_ctrl = 1'b0;
    @(posedge clk);
    #3 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    idle(1);

    // Recovery after reset
    cfg_waits[0] = 0;
    issue(32'h1000_0000, 1'b0, 32'h0, 2'b01, 1'b0, 1'b1, RD0, 0, 1'b1);
    idle(3);

    n = 0;
    while ((sb.size() != 0 || hsel_q.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0 || hsel_q.size() != 0) begin
      $display("FAIL drain: %0d entries outstanding, required 0", sb.size() + hsel_q.size());
      $fatal(1, "bench aborted");
    end
    final_req = 1'b1;
    n = 0;
    while (!final_done && n < 10) begin
      @(posedge clk);
      n++;
    end
    if (!final_done) begin
      $display("FAIL final_check: monitor idle, required final checks");
      $fatal(1, "bench aborted");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "bench aborted");
  end

endmodule
